// File: rtl/ysyx_2022040010_dcache_tag_assoc_if.sv
// Tag-store <-> dcache-controller bundle: lookup, refill, victim info and flush writeback.
// wb handshake: wb_valid with stable wb_addr/wb_way is held until a rising edge sees wb_ready=1.
interface ysyx_2022040010_dcache_tag_assoc_if #(
  parameter int ADDR_W = 64,
  parameter int WAYS   = 2
);
  logic              req_valid;
  logic              req_we;
  logic              req_cacheable;
  logic [ADDR_W-1:0] req_addr;
  logic              hit;
  logic              miss;
  logic [WAYS-1:0]   hit_way;
  logic [WAYS-1:0]   victim_way;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_addr;
  logic              refill;
  logic              refill_dirty;
  logic              flush_start;
  logic              flush_inv;
  logic              busy;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [WAYS-1:0]   wb_way;
  logic              wb_ready;
  logic              flush_done;

  modport master (
    output req_valid, req_we, req_cacheable, req_addr, refill, refill_dirty,
           flush_start, flush_inv, wb_ready,
    input  hit, miss, hit_way, victim_way, victim_dirty, victim_addr,
           busy, wb_valid, wb_addr, wb_way, flush_done
  );

  modport slave (
    input  req_valid, req_we, req_cacheable, req_addr, refill, refill_dirty,
           flush_start, flush_inv, wb_ready,
    output hit, miss, hit_way, victim_way, victim_dirty, victim_addr,
           busy, wb_valid, wb_addr, wb_way, flush_done
  );
endinterface

// File: rtl/ysyx_2022040010_dcache_tag_assoc.sv
// N-way set-associative D-cache tag store with tree-PLRU replacement and a flush walker
// that writes back every dirty line (optionally invalidating) for fences and cache maintenance.
module ysyx_2022040010_dcache_tag_assoc #(
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = 3,
  parameter int INDEX_W  = 6,
  parameter int WAYS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  ysyx_2022040010_dcache_tag_assoc_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PLRU_W = WAYS - 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] set_q;
  logic [WAY_W-1:0]   way_q;
  logic               inv_q;

  // PLRU tree is heap-ordered: node n has children 2n/2n+1, leaves WAYS..2*WAYS-1;
  // a 0 bit means the victim lies in the left subtree.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [PLRU_W-1:0] bits);
    int   node;
    logic b;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < PLRU_W; n++) if (n + 1 == node) b = bits[n];
      node = 2 * node + int'(b);
    end
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    int                node;
    int                dir;
    logic [PLRU_W-1:0] r;
    r    = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir = (int'(way) >> (WAY_W - 1 - l)) & 1;
      for (int n = 0; n < PLRU_W; n++) if (n + 1 == node) r[n] = (dir == 0);
      node = 2 * node + dir;
    end
    return r;
  endfunction

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               busy, active, hit, miss;
  logic [WAYS-1:0]    hit_vec, vic_onehot;
  logic [WAY_W-1:0]   hit_idx, vic;
  logic               vic_found, vic_valid;
  logic               unused_offset;

  assign idx           = bus.req_addr[OFFSET_W +: INDEX_W];
  assign req_tag       = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];
  assign active        = bus.req_valid & bus.req_cacheable & ~busy;

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit_vec[w] = 1'b1;
        hit_idx    = WAY_W'(w);
      end
    end
  end

  assign hit  = active & (|hit_vec);
  assign miss = active & ~(|hit_vec);

  // Free ways are filled lowest-first; PLRU only decides once the set is full.
  always_comb begin
    vic       = plru_pick(plru_q[idx]);
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[idx][w]) begin
        vic       = WAY_W'(w);
        vic_found = 1'b1;
      end
    end
    vic_onehot = '0;
    for (int w = 0; w < WAYS; w++) vic_onehot[w] = (WAY_W'(w) == vic);
  end

  assign vic_valid = valid_q[idx][vic];

  // Flush walker control
  logic line_valid, line_dirty, last_line, advance, start;
  logic clr_valid, clr_dirty, clr_plru;
  logic wb_valid, flush_done;
  logic [ADDR_W-1:0] wb_addr;
  logic [WAYS-1:0]   wb_way;

  assign line_valid = valid_q[set_q][way_q];
  assign line_dirty = dirty_q[set_q][way_q];
  assign last_line  = (set_q == INDEX_W'(SETS - 1)) && (way_q == WAY_W'(WAYS - 1));
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    advance    = 1'b0;
    clr_valid  = 1'b0;
    clr_dirty  = 1'b0;
    clr_plru   = 1'b0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_way     = '0;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_start) begin
          start   = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (line_valid && line_dirty) begin
          state_d = S_WB;
        end else begin
          clr_valid = inv_q;
          advance   = 1'b1;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_addr  = {tag_q[set_q][way_q], set_q, OFFSET_W'(0)};
        for (int w = 0; w < WAYS; w++) wb_way[w] = (WAY_W'(w) == way_q);
        if (bus.wb_ready) begin
          clr_dirty = 1'b1;
          clr_valid = inv_q;
          advance   = 1'b1;
        end
      end
      S_DONE: begin
        flush_done = 1'b1;
        clr_plru   = inv_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) state_d = last_line ? S_DONE : S_SCAN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        set_q <= '0;
        way_q <= '0;
        inv_q <= bus.flush_inv;
      end else if (advance) begin
        // WAYS is a power of two, so the way counter carries straight into the set.
        {set_q, way_q} <= {set_q, way_q} + 1'b1;
      end
    end
  end

  // Lookup updates and flush updates never coincide: lookups are inactive while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (hit) begin
        plru_q[idx] <= plru_touch(plru_q[idx], hit_idx);
        if (bus.req_we) dirty_q[idx][hit_idx] <= 1'b1;
      end else if (miss && bus.refill) begin
        valid_q[idx][vic] <= 1'b1;
        dirty_q[idx][vic] <= bus.refill_dirty;
        plru_q[idx]       <= plru_touch(plru_q[idx], vic);
      end
      if (clr_valid) valid_q[set_q][way_q] <= 1'b0;
      if (clr_dirty) dirty_q[set_q][way_q] <= 1'b0;
      if (clr_plru) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss && bus.refill) tag_q[idx][vic] <= req_tag;
  end

  assign bus.hit          = hit;
  assign bus.miss         = miss;
  assign bus.hit_way      = hit_vec & {WAYS{active}};
  assign bus.victim_way   = vic_onehot;
  assign bus.victim_dirty = vic_valid & dirty_q[idx][vic];
  assign bus.victim_addr  = vic_valid ? {tag_q[idx][vic], idx, OFFSET_W'(0)} : '0;
  assign bus.busy         = busy;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_addr      = wb_addr;
  assign bus.wb_way       = wb_way;
  assign bus.flush_done   = flush_done;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_ysyx_2022040010_dcache_tag_assoc.sv
// Randomized bench for the dcache tag store against an LRU/array reference model,
// with a writeback scoreboard for flush walks.
module tb_ysyx_2022040010_dcache_tag_assoc;
  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  ysyx_2022040010_dcache_tag_assoc_if #(.ADDR_W(64), .WAYS(WAYS)) bus ();

  ysyx_2022040010_dcache_tag_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // reference model: per-line state plus the least-recently-used way of each set
  bit          mv  [SETS][WAYS];
  bit          md  [SETS][WAYS];
  logic [54:0] mt  [SETS][WAYS];
  int          lru [SETS];

  logic [63:0] exp_q[$];
  logic [1:0]  exp_way_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      lru[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
        mt[s][w] = '0;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_cacheable = 1'b0;
    bus.req_addr      = '0;
    bus.refill        = 1'b0;
    bus.refill_dirty  = 1'b0;
    bus.flush_start   = 1'b0;
    bus.flush_inv     = 1'b0;
    bus.wb_ready      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One lookup cycle: drive, compare combinational outputs, then apply the edge to the model.
  task automatic access(input logic [63:0] a, input bit we, input bit cach, input bit v,
                        input bit rf, input bit rd);
    int          s, hw, vw;
    logic [54:0] t;
    bit          act, h, vd;
    logic [63:0] va;
    @(negedge clk);
    bus.req_valid     = v;
    bus.req_we        = we;
    bus.req_cacheable = cach;
    bus.req_addr      = a;
    bus.refill        = rf;
    bus.refill_dirty  = rd;
    bus.flush_start   = 1'b0;
    bus.wb_ready      = 1'($urandom_range(0, 1));
    #1;
    s   = int'(a[8:3]);
    t   = a[63:9];
    act = v & cach;
    h   = 0;
    hw  = 0;
    for (int w = 0; w < WAYS; w++)
      if (act && mv[s][w] && mt[s][w] == t) begin h = 1; hw = w; end
    vw = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : lru[s]);
    vd = mv[s][vw] & md[s][vw];
    va = mv[s][vw] ? {mt[s][vw], a[8:3], 3'b000} : 64'h0;
    check("hit", bus.hit, h);
    check("miss", bus.miss, act & ~h);
    check("hit_way", bus.hit_way, h ? (64'h1 << hw) : 64'h0);
    check("victim_way", bus.victim_way, 64'h1 << vw);
    check("victim_dirty", bus.victim_dirty, vd);
    check("victim_addr", bus.victim_addr, va);
    @(posedge clk);
    if (h) begin
      lru[s] = 1 - hw;
      if (we) md[s][hw] = 1;
    end else if (act && rf) begin
      mv[s][vw] = 1;
      md[s][vw] = rd;
      mt[s][vw] = t;
      lru[s]    = 1 - vw;
    end
  endtask

  task automatic run_flush(input bit inv, input int delay);
    int  c, wait_n, done_cnt, done_c, n_wb;
    bit  finished;
    exp_q.delete();
    exp_way_q.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (mv[s][w] && md[s][w]) begin
          exp_q.push_back({mt[s][w], 6'(s), 3'b000});
          exp_way_q.push_back(2'(1 << w));
        end
    n_wb = exp_q.size();
    @(negedge clk);
    idle_inputs();
    bus.flush_start = 1'b1;
    bus.flush_inv   = inv;
    c = 0; wait_n = 0; done_cnt = 0; done_c = 0; finished = 0;
    while (!finished && c < 3000) begin
      @(negedge clk);
      c++;
      bus.flush_start   = 1'($urandom_range(0, 1));
      bus.flush_inv     = 1'($urandom_range(0, 1));
      bus.req_valid     = 1'b1;
      bus.req_cacheable = 1'b1;
      bus.req_we        = 1'($urandom_range(0, 1));
      bus.req_addr      = {$urandom(), $urandom()};
      bus.refill        = 1'b1;
      #1;
      if (!bus.busy) begin
        idle_inputs();
        finished = 1;
      end else begin
        check("busy_hit", bus.hit, 0);
        check("busy_miss", bus.miss, 0);
        bus.wb_ready = 1'b0;
        if (bus.wb_valid) begin
          if (exp_q.size() == 0) begin
            check("wb_unexpected", bus.wb_valid, 0);
          end else begin
            check("wb_addr", bus.wb_addr, exp_q[0]);
            check("wb_way", bus.wb_way, exp_way_q[0]);
            if (wait_n == delay) begin
              bus.wb_ready = 1'b1;
              void'(exp_q.pop_front());
              void'(exp_way_q.pop_front());
              wait_n = 0;
            end else begin
              wait_n++;
            end
          end
        end
        if (bus.flush_done) begin
          done_cnt++;
          done_c = c;
        end
      end
    end
    check("flush_timeout", finished, 1);
    check("wb_left", exp_q.size(), 0);
    check("flush_done_count", done_cnt, 1);
    check("flush_done_cycle", done_c, SETS * WAYS + 1 + n_wb * (delay + 1));
    for (int s = 0; s < SETS; s++) begin
      if (inv) lru[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        md[s][w] = 0;
        if (inv) mv[s][w] = 0;
      end
    end
  endtask

  task automatic random_access();
    logic [54:0] t;
    logic [5:0]  ix;
    t  = 55'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) t[54] = 1'b1;
    ix = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
    access({t, ix, 3'($urandom_range(0, 7))}, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    idle_inputs();
    do_reset();
    #1;
    check("rst_hit", bus.hit, 0);
    check("rst_miss", bus.miss, 0);
    check("rst_hit_way", bus.hit_way, 0);
    check("rst_victim_way", bus.victim_way, 2'b01);
    check("rst_victim_dirty", bus.victim_dirty, 0);
    check("rst_victim_addr", bus.victim_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_addr", bus.wb_addr, 0);
    check("rst_wb_way", bus.wb_way, 0);
    check("rst_flush_done", bus.flush_done, 0);

    // fill, hit and PLRU eviction in set 0
    access(64'h1000, 0, 1, 1, 1, 0);
    access(64'h1000, 0, 1, 1, 0, 0);
    access(64'h2000, 0, 1, 1, 1, 0);
    access(64'h1000, 0, 1, 1, 0, 0);
    access(64'h3000, 0, 1, 1, 0, 0);

    // store miss leaves a dirty victim; uncacheable access changes nothing
    do_reset();
    access(64'h1008, 1, 1, 1, 1, 1);
    access(64'h2000, 0, 1, 1, 1, 0);
    access(64'h3000, 0, 1, 1, 0, 0);
    access(64'h3000, 1, 0, 1, 1, 1);
    access(64'h3000, 0, 1, 1, 0, 0);

    // two dirty lines, late wb_ready, keep valid
    do_reset();
    access(64'h1000, 0, 1, 1, 1, 0);
    access(64'h2000, 1, 1, 1, 1, 1);
    access(64'h3028, 1, 1, 1, 1, 1);
    run_flush(0, 2);
    access(64'h2000, 0, 1, 1, 0, 0);
    access(64'h3028, 0, 1, 1, 0, 0);

    // clean-cache invalidating walk
    run_flush(1, 0);
    access(64'h1000, 0, 1, 1, 0, 0);
    access(64'h2000, 0, 1, 1, 0, 0);
    access(64'h3028, 0, 1, 1, 0, 0);

    // reset while a writeback is pending
    access(64'h1000, 1, 1, 1, 1, 1);
    @(negedge clk);
    idle_inputs();
    bus.flush_start = 1'b1;
    @(negedge clk);
    bus.flush_start = 1'b0;
    for (int i = 0; i < 300 && !bus.wb_valid; i++) @(negedge clk);
    check("abort_reach_wb", bus.wb_valid, 1);
    rst = 1'b1;
    #1;
    check("abort_wb_valid", bus.wb_valid, 0);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    access(64'h1000, 0, 1, 1, 0, 0);

    // randomized traffic with periodic flushes
    do_reset();
    for (int i = 0; i < 600; i++) begin
      random_access();
      if (i % 150 == 149) run_flush(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
